// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the UART receive buffer: default sizing and capture FSM encodings.
package uart_rx_fifo_pkg;

  localparam int unsigned DATA_W          = 8;
  localparam int unsigned DEPTH_LOG2_DEF  = 4;
  localparam int unsigned AFULL_LEVEL_DEF = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_ACK  = 2'd2
  } rx_state_e;

endpackage

// File: rtl/uart_fifo_ram.sv
// Storage array for the receive FIFO: synchronous write, asynchronous read, no reset.
module uart_fifo_ram
  import uart_rx_fifo_pkg::*;
#(
  parameter int unsigned AW = DEPTH_LOG2_DEF,
  parameter int unsigned DW = DATA_W
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int unsigned ENTRIES = 1 << AW;

  logic [DW-1:0] mem [0:ENTRIES-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART receiver: captures bytes, acknowledges them, and queues
// them for the CPU; withholds the acknowledge while full so the receiver applies flow control.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2  = DEPTH_LOG2_DEF,
  parameter int unsigned AFULL_LEVEL = AFULL_LEVEL_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     rx_data,
  input  logic                  rx_recv,
  output logic                  rx_ack,
  input  logic                  cpu_rd,
  output logic [DATA_W-1:0]     cpu_data,
  output logic                  cpu_avail,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic                  almost_full,
  output logic                  overrun,
  input  logic                  overrun_clr,
  input  logic                  flush
);

  localparam int unsigned AW    = DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  rx_state_e         state_q, state_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              rx_ack_q, overrun_q, overrun_d;
  logic              avail_q, afull_q;
  logic [DATA_W-1:0] cpu_data_q, cpu_data_d;
  logic              wr_en, pop, space, ovr_set;
  logic [DATA_W-1:0] wr_data, ram_rdata;

  uart_fifo_ram #(
    .AW (AW),
    .DW (DATA_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr_q),
    .wdata (wr_data),
    .raddr (rd_ptr_d),
    .rdata (ram_rdata)
  );

  // Capture FSM, FIFO pointer/count update and next head-of-queue byte
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    wr_en      = 1'b0;
    wr_data    = hold_q;
    ovr_set    = 1'b0;
    pop        = cpu_rd && (count_q != '0);
    space      = count_q < CW'(DEPTH);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    cpu_data_d = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (rx_recv) begin
          hold_d = rx_data;
          if (space || pop) begin
            wr_en   = 1'b1;
            wr_data = rx_data;
            state_d = ST_ACK;
          end else begin
            state_d = ST_PEND;
          end
        end
      end
      ST_PEND: begin
        if (rx_recv) ovr_set = 1'b1;
        if (space) begin
          wr_en   = 1'b1;
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        if (rx_recv) ovr_set = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (flush) begin
      // Releasing a stalled receiver still needs its acknowledge pulse
      wr_en    = 1'b0;
      pop      = 1'b0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      state_d  = (state_q == ST_PEND) ? ST_ACK : ST_IDLE;
    end else begin
      wr_ptr_d = wr_ptr_q + AW'(wr_en);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      count_d  = count_q + CW'(wr_en) - CW'(pop);
    end

    // Bypass the byte being written when it becomes the new head (write into empty FIFO)
    if (count_d != '0) begin
      if (wr_en && (wr_ptr_q == rd_ptr_d)) cpu_data_d = wr_data;
      else                                 cpu_data_d = ram_rdata;
    end

    overrun_d = overrun_clr ? 1'b0 : (overrun_q | ovr_set);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      hold_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rx_ack_q   <= 1'b0;
      overrun_q  <= 1'b0;
      avail_q    <= 1'b0;
      afull_q    <= 1'b0;
      cpu_data_q <= '0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rx_ack_q   <= (state_d == ST_ACK);
      overrun_q  <= overrun_d;
      avail_q    <= (count_d != '0);
      afull_q    <= (count_d >= CW'(AFULL_LEVEL));
      cpu_data_q <= cpu_data_d;
    end
  end

  assign rx_ack      = rx_ack_q;
  assign cpu_data    = cpu_data_q;
  assign cpu_avail   = avail_q;
  assign fifo_count  = count_q;
  assign almost_full = afull_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: vector table, directed corner sequences and
// randomized traffic against a queue-based reference model.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_recv, rx_ack, cpu_rd, cpu_avail, almost_full, overrun, overrun_clr, flush;
  logic [7:0] cpu_data;
  logic [4:0] fifo_count;

  int n_tests = 0;
  int n_fail  = 0;

  uart_rx_fifo dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_data     (rx_data),
    .rx_recv     (rx_recv),
    .rx_ack      (rx_ack),
    .cpu_rd      (cpu_rd),
    .cpu_data    (cpu_data),
    .cpu_avail   (cpu_avail),
    .fifo_count  (fifo_count),
    .almost_full (almost_full),
    .overrun     (overrun),
    .overrun_clr (overrun_clr),
    .flush       (flush)
  );

  always #5 clk = ~clk;

  // Reference model: byte queue, a byte waiting for room, an ack due, sticky overrun
  logic [7:0] mq[$];
  bit         m_pend;
  logic [7:0] m_pbyte;
  bit         m_ack;
  bit         m_ovr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    mq.delete();
    m_pend = 0;
    m_ack  = 0;
    m_ovr  = 0;
  endfunction

  function automatic void model_step(input bit r, input logic [7:0] d, input bit rd,
                                     input bit clr, input bit fl);
    bit         pop, do_wr, set, nack, was_pend;
    logic [7:0] wb;
    pop = rd && (mq.size() != 0);
    do_wr = 0; set = 0; nack = 0; wb = 8'h00;
    was_pend = m_pend;
    if (m_pend) begin
      if (r) set = 1;
      if (mq.size() < 16) begin
        do_wr = 1; wb = m_pbyte; m_pend = 0; nack = 1;
      end
    end else if (m_ack) begin
      if (r) set = 1;
    end else if (r) begin
      if (mq.size() < 16 || pop) begin
        do_wr = 1; wb = d; nack = 1;
      end else begin
        m_pend = 1; m_pbyte = d;
      end
    end
    if (fl) begin
      mq.delete();
      m_pend = 0;
      nack   = was_pend;
    end else begin
      if (pop)   void'(mq.pop_front());
      if (do_wr) mq.push_back(wb);
    end
    m_ack = nack;
    m_ovr = clr ? 1'b0 : (m_ovr | set);
  endfunction

  task automatic check_model();
    logic [7:0] head;
    head = (mq.size() != 0) ? mq[0] : 8'h00;
    chk("rx_ack",      32'(rx_ack),      32'(m_ack));
    chk("fifo_count",  32'(fifo_count),  32'(mq.size()));
    chk("cpu_avail",   32'(cpu_avail),   32'(mq.size() != 0));
    chk("almost_full", 32'(almost_full), 32'(mq.size() >= 12));
    chk("cpu_data",    32'(cpu_data),    32'(head));
    chk("overrun",     32'(overrun),     32'(m_ovr));
  endtask

  // One clock: drive inputs, advance model, sample 1 time unit after the edge
  task automatic cycle(input bit r, input logic [7:0] d, input bit rd, input bit clr, input bit fl);
    rx_recv = r; rx_data = d; cpu_rd = rd; overrun_clr = clr; flush = fl;
    model_step(r, d, rd, clr, fl);
    @(posedge clk);
    #1;
    rx_recv = 0; cpu_rd = 0; overrun_clr = 0; flush = 0;
    check_model();
  endtask

  task automatic fill16(input logic [7:0] base);
    for (int i = 0; i < 16; i++) begin
      cycle(1, base + 8'(i), 0, 0, 0);
      cycle(0, 8'h00, 0, 0, 0);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_rx_ack"},      32'(rx_ack),      32'd0);
    chk({tag, "_cpu_avail"},   32'(cpu_avail),   32'd0);
    chk({tag, "_cpu_data"},    32'(cpu_data),    32'd0);
    chk({tag, "_fifo_count"},  32'(fifo_count),  32'd0);
    chk({tag, "_almost_full"}, 32'(almost_full), 32'd0);
    chk({tag, "_overrun"},     32'(overrun),     32'd0);
  endtask

  typedef struct {
    bit         r;
    logic [7:0] d;
    bit         rd;
    bit         clr;
    bit         fl;
    bit         e_ack;
    int         e_cnt;
    logic [7:0] e_data;
    bit         e_ovr;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int acks;
    int pin, pout;
    bit r, rd, clr, fl;

    //            r  d      rd clr fl  ack cnt data   ovr
    vecs[0] = '{1, 8'hA5, 0, 0, 0,  1,  1, 8'hA5, 0};  // single byte captured, acked next cycle
    vecs[1] = '{0, 8'h00, 0, 0, 0,  0,  1, 8'hA5, 0};
    vecs[2] = '{0, 8'h00, 1, 0, 0,  0,  0, 8'h00, 0};  // pop to empty
    vecs[3] = '{0, 8'h00, 1, 0, 0,  0,  0, 8'h00, 0};  // pop on empty ignored
    vecs[4] = '{1, 8'h3C, 1, 0, 0,  1,  1, 8'h3C, 0};  // simultaneous push/pop at empty
    vecs[5] = '{1, 8'h5A, 0, 0, 0,  0,  1, 8'h3C, 1};  // recv during ACK -> overrun
    vecs[6] = '{0, 8'h00, 0, 1, 0,  0,  1, 8'h3C, 0};
    vecs[7] = '{0, 8'h00, 1, 0, 0,  0,  0, 8'h00, 0};

    rst_n = 0; rx_data = 0; rx_recv = 0; cpu_rd = 0; overrun_clr = 0; flush = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst_n = 1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      cycle(vecs[i].r, vecs[i].d, vecs[i].rd, vecs[i].clr, vecs[i].fl);
      chk($sformatf("vec%0d_ack", i),   32'(rx_ack),     32'(vecs[i].e_ack));
      chk($sformatf("vec%0d_count", i), 32'(fifo_count), 32'(vecs[i].e_cnt));
      chk($sformatf("vec%0d_avail", i), 32'(cpu_avail),  32'(vecs[i].e_cnt != 0));
      chk($sformatf("vec%0d_data", i),  32'(cpu_data),   32'(vecs[i].e_data));
      chk($sformatf("vec%0d_ovr", i),   32'(overrun),    32'(vecs[i].e_ovr));
    end

    // Fill to 16, almost_full from the 12th write, 17th byte stalls until a pop
    for (int i = 0; i < 16; i++) begin
      cycle(1, 8'(i), 0, 0, 0);
      chk($sformatf("fill_afull%0d", i), 32'(almost_full), 32'(i >= 11));
      cycle(0, 8'h00, 0, 0, 0);
    end
    chk("fill_count", 32'(fifo_count), 32'd16);
    cycle(1, 8'h10, 0, 0, 0);
    chk("full_no_ack", 32'(rx_ack), 32'd0);
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      cycle(0, 8'h00, 0, 0, 0);
      acks += int'(rx_ack);
    end
    chk("full_still_no_ack", 32'(acks), 32'd0);
    chk("full_head", 32'(cpu_data), 32'h00);
    cycle(0, 8'h00, 1, 0, 0);
    chk("pop_next_head", 32'(cpu_data), 32'h01);
    chk("pop_count", 32'(fifo_count), 32'd15);
    cycle(0, 8'h00, 0, 0, 0);
    chk("pend_ack", 32'(rx_ack), 32'd1);
    chk("pend_count", 32'(fifo_count), 32'd16);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("drain%0d", k), 32'(cpu_data), 32'(k + 1));
      cycle(0, 8'h00, 1, 0, 0);
    end

    // Interleaved push/pop across pointer wrap
    for (int i = 0; i < 40; i++) begin
      if (i % 3 != 2) cycle(1, 8'h80 + 8'(i), 0, 0, 0);
      else            cycle(0, 8'h00, 1, 0, 0);
    end
    for (int i = 0; i < 20; i++) cycle(0, 8'h00, 1, 0, 0);
    chk("wrap_empty", 32'(fifo_count), 32'd0);

    // Simultaneous push and pop at full
    fill16(8'h20);
    cycle(1, 8'hEE, 1, 0, 0);
    chk("full_simul_count", 32'(fifo_count), 32'd16);
    chk("full_simul_ack", 32'(rx_ack), 32'd1);
    chk("full_simul_head", 32'(cpu_data), 32'h21);
    for (int k = 0; k < 16; k++) begin
      if (k == 15) chk("full_simul_tail", 32'(cpu_data), 32'hEE);
      cycle(0, 8'h00, 1, 0, 0);
    end

    // Overrun while pending keeps the first byte
    fill16(8'h40);
    cycle(1, 8'h77, 0, 0, 0);
    cycle(1, 8'h88, 0, 0, 0);
    chk("pend_overrun", 32'(overrun), 32'd1);
    cycle(0, 8'h00, 1, 0, 0);
    cycle(0, 8'h00, 0, 0, 0);
    for (int k = 0; k < 16; k++) begin
      if (k == 15) chk("pend_kept_byte", 32'(cpu_data), 32'h77);
      cycle(0, 8'h00, 1, 0, 0);
    end
    cycle(0, 8'h00, 0, 1, 0);
    chk("ovr_cleared", 32'(overrun), 32'd0);
    cycle(1, 8'h61, 0, 0, 0);
    cycle(1, 8'h62, 0, 1, 0);
    chk("clr_wins", 32'(overrun), 32'd0);
    cycle(0, 8'h00, 1, 0, 0);

    // Flush in PEND releases the receiver with a single ack
    fill16(8'hC0);
    cycle(1, 8'hD0, 0, 0, 0);
    cycle(0, 8'h00, 0, 0, 1);
    chk("flush_count", 32'(fifo_count), 32'd0);
    chk("flush_ack", 32'(rx_ack), 32'd1);
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      cycle(0, 8'h00, 0, 0, 0);
      acks += int'(rx_ack);
    end
    chk("flush_ack_once", 32'(acks), 32'd0);

    // Asynchronous reset mid-transfer
    cycle(1, 8'h5C, 0, 0, 0);
    #3;
    rst_n = 0;
    #1;
    check_reset_vals("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1;
    cycle(1, 8'h99, 0, 0, 0);
    chk("post_rst_data", 32'(cpu_data), 32'h99);
    cycle(0, 8'h00, 1, 0, 0);

    // Randomized traffic with phase-varying push/pop bias
    for (int i = 0; i < 900; i++) begin
      case ((i / 100) % 3)
        0:       begin pin = 80; pout = 20; end
        1:       begin pin = 20; pout = 80; end
        default: begin pin = 50; pout = 50; end
      endcase
      r   = $urandom_range(99) < 32'(pin);
      rd  = $urandom_range(99) < 32'(pout);
      clr = $urandom_range(19) == 0;
      fl  = $urandom_range(149) == 0;
      cycle(r, 8'($urandom), rd, clr, fl);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
